// File: rtl/rr_arb_pkg.sv
// Shared constants and types for the round-robin arbitrating mux.
// RR_ARB_MUX_LOCK_EN enables packet locking (in_last/out_last ports).
package rr_arb_pkg;

    // Pointer resets to the last index so requester 0 wins the first arbitration.
    localparam bit RR_PTR_RESET_IS_LAST = 1'b1;

    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after ptr_i, wrapping modulo INPUTS.
module rr_pick #(
    parameter  int INPUTS = 4,
    localparam int SW     = $clog2(INPUTS)
) (
    input  logic [INPUTS-1:0] req_i,
    input  logic [SW-1:0]     ptr_i,
    output logic [SW-1:0]     grant_o,
    output logic              any_o
);

    logic [SW:0] idx;

    // Walk offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        grant_o = '0;
        any_o   = |req_i;
        idx     = '0;
        for (int k = INPUTS; k >= 1; k--) begin
            idx = {1'b0, ptr_i} + (SW+1)'(k);
            if (idx >= (SW+1)'(INPUTS)) idx = idx - (SW+1)'(INPUTS);
            if (req_i[idx[SW-1:0]]) grant_o = idx[SW-1:0];
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// Round-robin N:1 valid/ready mux with a registered output stage.
// Define RR_ARB_MUX_LOCK_EN to hold a grant until in_last closes the packet.
module rr_arb_mux
    import rr_arb_pkg::*;
#(
    parameter  int INPUTS = 4,
    parameter  int WIDTH  = 8,
    localparam int SW     = $clog2(INPUTS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [INPUTS-1:0] in_valid,
    input  logic [WIDTH-1:0]  in_data [INPUTS-1:0],
    output logic [INPUTS-1:0] in_ready,
`ifdef RR_ARB_MUX_LOCK_EN
    input  logic [INPUTS-1:0] in_last,
    output logic              out_last,
`endif
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    output logic [SW-1:0]     out_src,
    input  logic              out_ready
);

    localparam logic [SW-1:0] PTR_RST = RR_PTR_RESET_IS_LAST ? SW'(INPUTS-1) : '0;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SW-1:0]    out_src_q, out_src_d;
    logic [SW-1:0]    ptr_q, ptr_d;
    logic [SW-1:0]    pick_grant, grant;
    logic             pick_any, any;
    logic             load_en, xfer;

    rr_pick #(.INPUTS(INPUTS)) u_pick (
        .req_i   (in_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .any_o   (pick_any)
    );

`ifdef RR_ARB_MUX_LOCK_EN
    lock_state_t   lock_q, lock_d;
    logic [SW-1:0] lock_idx_q, lock_idx_d;
    logic          out_last_q, out_last_d;

    // While a packet is open only its owner may be granted.
    always_comb begin
        grant = pick_grant;
        any   = pick_any;
        if (lock_q == LOCKED) begin
            grant = lock_idx_q;
            any   = in_valid[lock_idx_q];
        end
    end
    assign out_last = out_last_q;
`else
    assign grant = pick_grant;
    assign any   = pick_any;
`endif

    assign load_en = !out_valid_q || out_ready;
    assign xfer    = load_en && any && !reset;

    always_comb begin
        in_ready = '0;
        if (xfer) in_ready[grant] = 1'b1;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;
`ifdef RR_ARB_MUX_LOCK_EN
        lock_d      = lock_q;
        lock_idx_d  = lock_idx_q;
        out_last_d  = out_last_q;
`endif
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[grant];
            out_src_d   = grant;
            ptr_d       = grant;
`ifdef RR_ARB_MUX_LOCK_EN
            lock_d      = in_last[grant] ? UNLOCKED : LOCKED;
            lock_idx_d  = grant;
            out_last_d  = in_last[grant];
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            ptr_q       <= PTR_RST;
`ifdef RR_ARB_MUX_LOCK_EN
            lock_q      <= UNLOCKED;
            lock_idx_q  <= '0;
            out_last_q  <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
`ifdef RR_ARB_MUX_LOCK_EN
            lock_q      <= lock_d;
            lock_idx_q  <= lock_idx_d;
            out_last_q  <= out_last_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: directed vector table, hand sequences, random vs reference model.
module tb_rr_arb_mux;
    localparam int N = 4;
    localparam int W = 8;

    logic         clock = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] vld = '0;
    logic         ordy = 1'b0;
    logic [W-1:0] din [N-1:0];
    logic [N-1:0] in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   out_src;
`ifdef RR_ARB_MUX_LOCK_EN
    logic [N-1:0] last = '1;
    logic         out_last;
`endif

    always #5 clock = ~clock;

    rr_arb_mux #(.INPUTS(N), .WIDTH(W)) dut (
        .clock     (clock),
        .reset     (rst),
        .in_valid  (vld),
        .in_data   (din),
        .in_ready  (in_ready),
`ifdef RR_ARB_MUX_LOCK_EN
        .in_last   (last),
        .out_last  (out_last),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (ordy)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: held beat, last granted index, consumer log, wait counters.
    logic         m_ov = 1'b0;
    logic [W-1:0] m_od = '0;
    int           m_os = 0;
    int           m_last = N-1;
    int           waits [N];
    int           seen77 = 0;
`ifdef RR_ARB_MUX_LOCK_EN
    logic         m_lock = 1'b0;
    int           m_lidx = 0;
    logic         m_olast = 1'b0;
`endif

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r = '0;
        if (rst || (m_ov && !ordy)) return r;
`ifdef RR_ARB_MUX_LOCK_EN
        if (m_lock) begin
            if (vld[m_lidx]) r[m_lidx] = 1'b1;
            return r;
        end
`endif
        for (int k = 1; k <= N; k++) begin
            int idx = (m_last + k) % N;
            if (vld[idx]) begin
                r[idx] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic model_update(input logic [N-1:0] r);
        int g = -1;
        if (m_ov && ordy && m_od == 8'h77 && m_os == 0) seen77++;
        for (int i = 0; i < N; i++) if (r[i]) g = i;
        if (rst) begin
            m_ov = 1'b0; m_od = '0; m_os = 0; m_last = N-1;
            for (int i = 0; i < N; i++) waits[i] = 0;
`ifdef RR_ARB_MUX_LOCK_EN
            m_lock = 1'b0; m_olast = 1'b0;
`endif
        end else if (g >= 0) begin
            m_ov = 1'b1; m_od = din[g]; m_os = g; m_last = g;
`ifdef RR_ARB_MUX_LOCK_EN
            m_lock = !last[g]; m_lidx = g; m_olast = last[g];
`endif
            chk("fair_wait", waits[g], waits[g] <= N-1 ? waits[g] : N-1);
            for (int i = 0; i < N; i++) if (vld[i] && i != g) waits[i]++;
            waits[g] = 0;
        end else if (ordy) begin
            m_ov = 1'b0;
        end
    endtask

    // One clock: check comb ready, advance model on the edge, check registered outputs.
    task automatic cycle(output logic [N-1:0] rdy_seen);
        logic [N-1:0] er;
        #1;
        er = model_ready();
        chk("model_in_ready", in_ready, er);
        rdy_seen = in_ready;
        @(posedge clock);
        model_update(er);
        #1;
        chk("model_out_valid", out_valid, m_ov);
        chk("model_out_data", out_data, m_od);
        chk("model_out_src", out_src, m_os);
`ifdef RR_ARB_MUX_LOCK_EN
        chk("model_out_last", out_last, m_olast);
`endif
    endtask

    typedef struct {
        logic         rst;
        logic [N-1:0] vld;
        logic         ordy;
        logic [N-1:0][W-1:0] d;
        logic [N-1:0] erdy;
        logic         eov;
        logic [W-1:0] eod;
        logic [1:0]   eos;
    } vec_t;

    function automatic vec_t mk(logic r, logic [3:0] v, logic o, logic [7:0] d0, logic [7:0] d1,
                                logic [7:0] d2, logic [7:0] d3, logic [3:0] er, logic eov,
                                logic [7:0] eod, logic [1:0] eos);
        vec_t t;
        t.rst = r; t.vld = v; t.ordy = o;
        t.d[0] = d0; t.d[1] = d1; t.d[2] = d2; t.d[3] = d3;
        t.erdy = er; t.eov = eov; t.eod = eod; t.eos = eos;
        return t;
    endfunction

    vec_t vecs [$];

    initial begin
        logic [N-1:0] rs;
        logic [N-1:0] acc;
        for (int i = 0; i < N; i++) begin din[i] = '0; waits[i] = 0; end

        // Reset with all valid, then full rotation, single streamer, backpressure.
        repeat (3) vecs.push_back(mk(1, 4'b1111, 1, 8'h00, 8'h10, 8'h20, 8'h30, 4'b0000, 0, 8'h00, 0));
        vecs.push_back(mk(0, 4'b1111, 1, 8'h00, 8'h10, 8'h20, 8'h30, 4'b0001, 1, 8'h00, 0));
        vecs.push_back(mk(0, 4'b1111, 1, 8'h01, 8'h10, 8'h20, 8'h30, 4'b0010, 1, 8'h10, 1));
        vecs.push_back(mk(0, 4'b1111, 1, 8'h01, 8'h11, 8'h20, 8'h30, 4'b0100, 1, 8'h20, 2));
        vecs.push_back(mk(0, 4'b1111, 1, 8'h01, 8'h11, 8'h21, 8'h30, 4'b1000, 1, 8'h30, 3));
        vecs.push_back(mk(0, 4'b1111, 1, 8'h01, 8'h11, 8'h21, 8'h31, 4'b0001, 1, 8'h01, 0));
        vecs.push_back(mk(0, 4'b1111, 1, 8'h02, 8'h11, 8'h21, 8'h31, 4'b0010, 1, 8'h11, 1));
        for (int n = 0; n < 5; n++)
            vecs.push_back(mk(0, 4'b0100, 1, 8'h00, 8'h00, 8'hA0 + 8'(n), 8'h00, 4'b0100, 1, 8'hA0 + 8'(n), 2));
        vecs.push_back(mk(0, 4'b0000, 1, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 0, 8'hA4, 2));
        vecs.push_back(mk(0, 4'b0010, 0, 8'h00, 8'h55, 8'h00, 8'h00, 4'b0010, 1, 8'h55, 1));
        repeat (4) vecs.push_back(mk(0, 4'b1000, 0, 8'h00, 8'h00, 8'h00, 8'h33, 4'b0000, 1, 8'h55, 1));
        vecs.push_back(mk(0, 4'b1000, 1, 8'h00, 8'h00, 8'h00, 8'h33, 4'b1000, 1, 8'h33, 3));
        vecs.push_back(mk(0, 4'b0000, 1, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 0, 8'h33, 3));

        foreach (vecs[j]) begin
            rst = vecs[j].rst; vld = vecs[j].vld; ordy = vecs[j].ordy;
            for (int i = 0; i < N; i++) din[i] = vecs[j].d[i];
            cycle(rs);
            chk($sformatf("vec%0d_rdy", j), rs, vecs[j].erdy);
            chk($sformatf("vec%0d_ov", j), out_valid, vecs[j].eov);
            chk($sformatf("vec%0d_od", j), out_data, vecs[j].eod);
            chk($sformatf("vec%0d_os", j), out_src, vecs[j].eos);
        end

        // Reset while a beat is held: it must vanish without being consumed.
        vld = 4'b0001; din[0] = 8'h77; ordy = 1'b0;
        cycle(rs);
        chk("rstmid_load", out_data, 8'h77);
        vld = '0;
        cycle(rs);
        rst = 1'b1; vld = 4'b0001; din[0] = 8'h78;
        cycle(rs);
        chk("rstmid_rdy", rs, 4'b0000);
        chk("rstmid_ov", out_valid, 1'b0);
        rst = 1'b0; vld = '0; ordy = 1'b1;
        cycle(rs);
        chk("rstmid_ov2", out_valid, 1'b0);
        chk("rstmid_never_seen", seen77, 0);

`ifdef RR_ARB_MUX_LOCK_EN
        // Three-beat packet from src 0 must not be interleaved by src 1.
        vld = 4'b0011; din[1] = 8'hD0; last = 4'b0000;
        for (int b = 0; b < 3; b++) begin
            din[0] = 8'hC0 + 8'(b);
            if (b == 2) last = 4'b0001;
            cycle(rs);
            chk($sformatf("lock_b%0d_rdy", b), rs, 4'b0001);
            chk($sformatf("lock_b%0d_last", b), out_last, b == 2);
        end
        vld = 4'b0010; last = '1;
        cycle(rs);
        chk("lock_release_rdy", rs, 4'b0010);
        chk("lock_release_src", out_src, 2'd1);
        vld = '0;
        cycle(rs);
`endif

        // Random traffic with hold-until-accepted requesters.
        for (int c = 0; c < 600; c++) begin
            rst  = ($urandom_range(0, 99) == 0);
            ordy = ($urandom_range(0, 9) < 7);
            cycle(rs);
            acc = rs & vld;
            for (int i = 0; i < N; i++)
                if (!vld[i] || acc[i]) begin
                    vld[i] = 1'($urandom_range(0, 1));
                    din[i] = 8'($urandom);
                end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
